// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS transmit sequencer: FSM state encoding,
// pattern-length select codes, frame lengths and link header bit values.
package prbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_HDR0  = 3'd2,
    ST_PAY   = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  localparam logic [1:0] LEN_7  = 2'b00;
  localparam logic [1:0] LEN_11 = 2'b01;
  localparam logic [1:0] LEN_15 = 2'b10;
  localparam logic [1:0] LEN_31 = 2'b11;

  localparam logic [15:0] FRAME_LEN_7  = 16'd127;
  localparam logic [15:0] FRAME_LEN_11 = 16'd2047;
  localparam logic [15:0] FRAME_LEN_15 = 16'd32767;

  // Link framing header: a one followed by a zero ahead of the payload.
  localparam logic HDR_FIRST  = 1'b1;
  localparam logic HDR_SECOND = 1'b0;

  // Payload length in bits for a length-select code; the 31-bit pattern
  // uses a capped length supplied by the caller.
  function automatic logic [15:0] frame_len(input logic [1:0] code,
                                            input logic [15:0] len31);
    logic [15:0] len;
    len = len31;
    case (code)
      LEN_7:   len = FRAME_LEN_7;
      LEN_11:  len = FRAME_LEN_11;
      LEN_15:  len = FRAME_LEN_15;
      LEN_31:  len = len31;
      default: len = len31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/prbs_byte_packer.sv
// Packs a serial bit stream LSB-first into BYTE_W-bit words.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        drop any partial word (byte_out is kept)
//   bit_valid    bit_in is accepted this cycle
//   bit_in       payload bit
//   flush        emit a held partial word, zero-padded in its upper bits
//   byte_out     last completed word, registered
//   strobe       one-cycle pulse: byte_out was just updated
module prbs_byte_packer #(
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              flush,
  output logic [BYTE_W-1:0] byte_out,
  output logic              strobe
);

  localparam int unsigned IDX_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  logic [BYTE_W-1:0] pack_q, pack_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              strobe_q, strobe_d;

  always_comb begin
    pack_d   = pack_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;
    if (clear) begin
      pack_d = '0;
      idx_d  = '0;
    end else if (flush) begin
      // Unfilled positions are already zero because pack is cleared per word.
      if (idx_q != '0) begin
        byte_d   = pack_q;
        strobe_d = 1'b1;
      end
      pack_d = '0;
      idx_d  = '0;
    end else if (bit_valid) begin
      pack_d[idx_q] = bit_in;
      if (idx_q == IDX_W'(BYTE_W - 1)) begin
        byte_d   = pack_d;
        strobe_d = 1'b1;
        pack_d   = '0;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q   <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      pack_q   <= pack_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
    end
  end

  assign byte_out = byte_q;
  assign strobe   = strobe_q;

endmodule

// File: rtl/prbs_tx_sequencer.sv
// PRBS transmit sequencer: paces the selected PRBS generator on a divided
// tick, frames its output for the serial link (header 1,0 then payload) and
// packs the same payload LSB-first into bytes for the DAC bus.
// Ports:
//   CLOCK_50, reset      clock and synchronous active-high reset
//   start, abort         single-cycle frame request / termination
//   len_sel              pattern length select, sampled on accepted start
//   gen_bit              current MSB of the selected generator
//   gen_load, gen_step   generator reseed / advance pulses
//   link_bit             serial link bit, registered
//   dac_byte, dac_strobe packed payload byte and its valid pulse
//   busy, done           frame in progress / normal completion pulse
module prbs_tx_sequencer
  import prbs_pkg::*;
#(
  parameter int unsigned DIV_LOG2     = 8,
  parameter int unsigned FRAME31_BITS = 65535,
  parameter int unsigned BYTE_W       = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        len_sel,
  input  logic              gen_bit,
  output logic              gen_load,
  output logic              gen_step,
  output logic              link_bit,
  output logic [BYTE_W-1:0] dac_byte,
  output logic              dac_strobe,
  output logic              busy,
  output logic              done
);

  logic [DIV_LOG2-1:0] div_q, div_d;
  state_e              state_q, state_d;
  logic [1:0]          len_q, len_d;
  logic [15:0]         bit_cnt_q, bit_cnt_d;
  logic                link_q, link_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic                pk_valid, pk_flush, pk_clear;

  assign tick = &div_q;

  always_comb begin
    div_d     = div_q + DIV_LOG2'(1);
    state_d   = state_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    link_d    = link_q;
    busy_d    = busy_q;
    pk_valid  = 1'b0;
    pk_flush  = 1'b0;
    pk_clear  = 1'b0;
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = len_sel;
          gen_load  = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (tick) begin
          link_d  = HDR_FIRST;
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (tick) begin
          link_d  = HDR_SECOND;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (tick) begin
          gen_step  = 1'b1;
          link_d    = gen_bit;
          pk_valid  = 1'b1;
          bit_cnt_d = bit_cnt_q + 16'd1;
          if (bit_cnt_q == frame_len(len_q, 16'(FRAME31_BITS)) - 16'd1)
            state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        pk_flush  = 1'b1;
        done      = 1'b1;
        link_d    = 1'b0;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the active state would have done this cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      link_d    = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      gen_step  = 1'b0;
      pk_valid  = 1'b0;
      pk_flush  = 1'b0;
      pk_clear  = 1'b1;
      done      = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_q     <= '0;
      state_q   <= ST_IDLE;
      len_q     <= LEN_7;
      bit_cnt_q <= '0;
      link_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      link_q    <= link_d;
      busy_q    <= busy_d;
    end
  end

  prbs_byte_packer #(.BYTE_W(BYTE_W)) u_packer (
    .clk       (CLOCK_50),
    .reset     (reset),
    .clear     (pk_clear),
    .bit_valid (pk_valid),
    .bit_in    (gen_bit),
    .flush     (pk_flush),
    .byte_out  (dac_byte),
    .strobe    (dac_strobe)
  );

  assign link_bit = link_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_prbs_tx_sequencer.sv
module tb_prbs_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #10 clk = ~clk;

  // DUT 0: DIV_LOG2=2
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic [1:0] len0 = 2'b00;
  logic       gen_bit0, gen_load0, gen_step0, link0, strobe0, busy0, done0;
  logic [7:0] byte0;
  // DUT 1: DIV_LOG2=1
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [1:0] len1 = 2'b01;
  logic       gen_bit1, gen_load1, gen_step1, link1, strobe1, busy1, done1;
  logic [7:0] byte1;

  prbs_tx_sequencer #(.DIV_LOG2(2), .FRAME31_BITS(65535), .BYTE_W(8)) dut0 (
    .CLOCK_50(clk), .reset(reset), .start(start0), .abort(abort0),
    .len_sel(len0), .gen_bit(gen_bit0), .gen_load(gen_load0),
    .gen_step(gen_step0), .link_bit(link0), .dac_byte(byte0),
    .dac_strobe(strobe0), .busy(busy0), .done(done0));

  prbs_tx_sequencer #(.DIV_LOG2(1), .FRAME31_BITS(65535), .BYTE_W(8)) dut1 (
    .CLOCK_50(clk), .reset(reset), .start(start1), .abort(abort1),
    .len_sel(len1), .gen_bit(gen_bit1), .gen_load(gen_load1),
    .gen_step(gen_step1), .link_bit(link1), .dac_byte(byte1),
    .dac_strobe(strobe1), .busy(busy1), .done(done1));

  // Generator models: PRBS7 (x^7+x^6+1, seed 1) or constant for dut0,
  // alternating 1,0,... for dut1.
  logic       use_prbs = 1'b0;
  logic       const0 = 1'b1;
  logic [6:0] lfsr = 7'd1;
  logic       alt1 = 1'b1;
  assign gen_bit0 = use_prbs ? lfsr[6] : const0;
  assign gen_bit1 = alt1;

  always @(posedge clk) begin
    if (gen_load0)      lfsr <= 7'd1;
    else if (gen_step0) lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    if (gen_load1)      alt1 <= 1'b1;
    else if (gen_step1) alt1 <= ~alt1;
  end

  // Monitors sample at the falling edge.
  logic [7:0] bytes0[$];
  logic [7:0] bytes1[$];
  logic       sent0[$];
  logic       linkq0[$];
  int         steps0 = 0, loads0 = 0, dones0 = 0;
  int         steps1 = 0, loads1 = 0, dones1 = 0;
  logic       prev_step0 = 1'b0;
  logic [7:0] hist0 = '0;
  logic [1:0] hdr0 = 2'b00;

  always @(negedge clk) begin
    if (prev_step0) linkq0.push_back(link0);
    if (gen_step0 && steps0 == 0) hdr0 = {hist0[3], link0};
    if (gen_step0) begin
      sent0.push_back(gen_bit0);
      steps0++;
    end
    if (gen_load0) loads0++;
    if (done0)     dones0++;
    if (strobe0)   bytes0.push_back(byte0);
    prev_step0 = gen_step0;
    hist0 = {hist0[6:0], link0};
    if (gen_step1) steps1++;
    if (gen_load1) loads1++;
    if (done1)     dones1++;
    if (strobe1)   bytes1.push_back(byte1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic clear_mon();
    bytes0.delete(); bytes1.delete(); sent0.delete(); linkq0.delete();
    steps0 = 0; loads0 = 0; dones0 = 0;
    steps1 = 0; loads1 = 0; dones1 = 0;
    hdr0 = 2'b00;
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  task automatic wait_done0(input int budget, output logic seen,
                            output logic busy_at, output logic busy_after);
    seen = 1'b0; busy_at = 1'b0; busy_after = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done0) begin
        seen = 1'b1;
        busy_at = busy0;
        @(negedge clk);
        busy_after = busy0;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
    n_checks++; if (link0 !== 1'b0) begin n_fail++; $display("FAIL reset_link got %b want 0", link0); end
    n_checks++; if (byte0 !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", byte0); end
    for (int i = 0; i < 1000; i++) begin
      if ({busy0, link0, strobe0, gen_load0, gen_step0, done0, byte0} !== 14'd0) bad++;
      if ({busy1, link1, strobe1, gen_load1, gen_step1, done1, byte1} !== 14'd0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet got %0d active cycles want 0", bad); end
  endtask

  task automatic run_ones_frame(input string tag);
    logic seen, b_at, b_after;
    int nff;
    clear_mon();
    use_prbs = 1'b0; const0 = 1'b1; len0 = 2'b00;
    pulse_start0();
    wait_done0(2000, seen, b_at, b_after);
    nff = 0;
    for (int k = 0; k < 15 && k < bytes0.size(); k++) if (bytes0[k] !== 8'hFF) nff++;
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL %s_done_seen got %b want 1", tag, seen); end
    n_checks++; if (dones0 !== 1) begin n_fail++; $display("FAIL %s_done_count got %0d want 1", tag, dones0); end
    n_checks++; if ({b_at, b_after} !== 2'b10) begin n_fail++; $display("FAIL %s_busy_around_done got %b want 10", tag, {b_at, b_after}); end
    n_checks++; if (steps0 !== 127) begin n_fail++; $display("FAIL %s_gen_steps got %0d want 127", tag, steps0); end
    n_checks++; if (loads0 !== 1) begin n_fail++; $display("FAIL %s_gen_loads got %0d want 1", tag, loads0); end
    n_checks++; if (bytes0.size() !== 16) begin n_fail++; $display("FAIL %s_strobes got %0d want 16", tag, bytes0.size()); end
    n_checks++; if (nff !== 0) begin n_fail++; $display("FAIL %s_full_bytes got %0d non-FF want 0", tag, nff); end
    if (bytes0.size() == 16) begin
      n_checks++; if (bytes0[15] !== 8'h7F) begin n_fail++; $display("FAIL %s_last_byte got %h want 7f", tag, bytes0[15]); end
    end
    n_checks++; if (hdr0 !== 2'b10) begin n_fail++; $display("FAIL %s_header got %b want 10", tag, hdr0); end
  endtask

  task automatic test_ones_frame();
    int nbad;
    run_ones_frame("ones");
    nbad = 0;
    foreach (linkq0[i]) if (linkq0[i] !== 1'b1) nbad++;
    n_checks++; if (linkq0.size() !== 127 || nbad !== 0) begin n_fail++; $display("FAIL ones_link got %0d bits %0d zero want 127 bits 0 zero", linkq0.size(), nbad); end
  endtask

  task automatic test_prbs_frame();
    logic seen, b_at, b_after;
    logic [7:0] exp;
    int nbad;
    clear_mon();
    use_prbs = 1'b1; len0 = 2'b00;
    pulse_start0();
    wait_done0(2000, seen, b_at, b_after);
    n_checks++; if (seen !== 1'b1 || sent0.size() !== 127 || bytes0.size() !== 16) begin
      n_fail++; $display("FAIL prbs_frame got done=%b bits=%0d bytes=%0d want 1 127 16", seen, sent0.size(), bytes0.size());
    end else begin
      n_checks++; if (bytes0[0] !== 8'h40) begin n_fail++; $display("FAIL prbs_byte0 got %h want 40", bytes0[0]); end
      n_checks++; if (bytes0[1] !== 8'h30) begin n_fail++; $display("FAIL prbs_byte1 got %h want 30", bytes0[1]); end
      nbad = 0;
      for (int k = 0; k < 16; k++) begin
        exp = '0;
        for (int b = 0; b < 8; b++) if (8 * k + b < 127) exp[b] = sent0[8 * k + b];
        if (bytes0[k] !== exp) nbad++;
      end
      n_checks++; if (nbad !== 0) begin n_fail++; $display("FAIL prbs_bytes got %0d wrong bytes want 0", nbad); end
      nbad = 0;
      for (int i = 0; i < 127; i++) if (i >= linkq0.size() || linkq0[i] !== sent0[i]) nbad++;
      n_checks++; if (nbad !== 0) begin n_fail++; $display("FAIL prbs_link got %0d wrong bits want 0", nbad); end
    end
    use_prbs = 1'b0;
  endtask

  task automatic test_abort();
    int guard;
    clear_mon();
    const0 = 1'b1; len0 = 2'b00;
    pulse_start0();
    guard = 0;
    while (steps0 < 40 && guard < 2000) begin @(negedge clk); guard++; end
    n_checks++; if (steps0 !== 40) begin n_fail++; $display("FAIL abort_reach40 got %0d want 40", steps0); end
    @(posedge clk); #1 abort0 = 1'b1;
    @(posedge clk); #1 abort0 = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy0, link0} !== 2'b00) begin n_fail++; $display("FAIL abort_idle got busy,link=%b want 00", {busy0, link0}); end
    repeat (200) @(negedge clk);
    n_checks++; if (bytes0.size() !== 5) begin n_fail++; $display("FAIL abort_strobes got %0d want 5", bytes0.size()); end
    n_checks++; if (dones0 !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", dones0); end
    n_checks++; if (steps0 !== 40) begin n_fail++; $display("FAIL abort_steps got %0d want 40", steps0); end
    run_ones_frame("after_abort");
  endtask

  task automatic test_start_ignored();
    logic seen, b_at, b_after;
    int guard;
    clear_mon();
    const0 = 1'b1; len0 = 2'b00;
    pulse_start0();
    guard = 0;
    while (steps0 < 10 && guard < 2000) begin @(negedge clk); guard++; end
    @(posedge clk); #1 start0 = 1'b1; len0 = 2'b01;
    @(posedge clk); #1 start0 = 1'b0;
    wait_done0(2000, seen, b_at, b_after);
    n_checks++; if (steps0 !== 127) begin n_fail++; $display("FAIL restart_steps got %0d want 127", steps0); end
    n_checks++; if (loads0 !== 1) begin n_fail++; $display("FAIL restart_loads got %0d want 1", loads0); end
    n_checks++; if (bytes0.size() !== 16) begin n_fail++; $display("FAIL restart_strobes got %0d want 16", bytes0.size()); end
    n_checks++; if (dones0 !== 1) begin n_fail++; $display("FAIL restart_done got %0d want 1", dones0); end
    len0 = 2'b00;
  endtask

  task automatic test_alternating();
    int guard, nbad;
    clear_mon();
    len1 = 2'b01;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    guard = 0;
    while (dones1 == 0 && guard < 10000) begin @(negedge clk); guard++; end
    repeat (4) @(negedge clk);
    nbad = 0;
    foreach (bytes1[k]) if (bytes1[k] !== 8'h55) nbad++;
    n_checks++; if (dones1 !== 1) begin n_fail++; $display("FAIL alt_done got %0d want 1", dones1); end
    n_checks++; if (steps1 !== 2047) begin n_fail++; $display("FAIL alt_steps got %0d want 2047", steps1); end
    n_checks++; if (bytes1.size() !== 256) begin n_fail++; $display("FAIL alt_strobes got %0d want 256", bytes1.size()); end
    n_checks++; if (nbad !== 0) begin n_fail++; $display("FAIL alt_bytes got %0d non-55 want 0", nbad); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL alt_busy_end got %b want 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_ones_frame();
    test_prbs_frame();
    test_abort();
    test_start_ignored();
    test_alternating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
